// File: rtl/mem_pkg.sv
// =============================================================================
//  mem_pkg : shared size encodings, FSM states and byte-order helper
//  Revision: 1.0
// =============================================================================
`default_nettype none

package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WR     = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    // Memory read data carries the base byte in [31:24]; flip to base-in-[7:0].
    function automatic logic [31:0] byte_swap32(input logic [31:0] r);
        return {r[7:0], r[15:8], r[23:16], r[31:24]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// =============================================================================
//  mem_lane_align : load extract/extend and store merge on a base-in-[7:0] word
//  Revision: 1.0
// =============================================================================
`default_nettype none

module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] i_le,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Half accesses are only legal at lanes 0 and 2, so lane[1] picks the half.
    assign w_byte = i_le[{i_lane, 3'b000} +: 8];
    assign w_half = i_le[{i_lane[1], 4'b0000} +: 16];

    always_comb begin
        o_load   = i_le;
        o_merged = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_load   = {{24{i_signed & w_byte[7]}}, w_byte};
                o_merged = i_le;
                o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
            end
            SZ_HALF: begin
                o_load   = {{16{i_signed & w_half[15]}}, w_half};
                o_merged = i_le;
                o_merged[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_master.sv
// =============================================================================
//  mem_master : CPU load/store to 32-bit memory port bridge with sub-word RMW
//  Revision: 1.0
// =============================================================================
`default_nettype none

module mem_master
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       write_data,
    input  logic [31:0]       mem_out,
    output logic              _mem_read,
    output logic              _mem_write
);

    localparam logic [ADDR_W:0] c_MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_lane;
    logic [1:0]          r_size;
    logic                r_signed;
    logic [31:0]         r_wdata;
    logic [31:0]         r_merge;
    logic [31:0]         r_rdata;
    logic                r_err;
    logic [ADDR_W-1:0]   r_address;

    logic [ADDR_W-1:0]   w_base;
    logic                w_accept;
    logic                w_err;
    logic [31:0]         w_le;
    logic [31:0]         w_load;
    logic [31:0]         w_merged;

    assign w_base   = {req_addr[ADDR_W-1:2], 2'b00};
    assign w_accept = req_valid && req_ready;
    assign w_err    = (req_size == 2'd3)
                   || (req_size == SZ_HALF && req_addr[0])
                   || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
                   || (({1'b0, w_base} + (ADDR_W+1)'(3)) >= c_MEM_LIMIT);
    assign w_le     = byte_swap32(mem_out);

    mem_lane_align u_align (
        .i_le     (w_le),
        .i_lane   (r_lane),
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_wdata  (r_wdata),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_err)                   w_next = ST_RESP;
                    else if (!req_write)         w_next = ST_RD;
                    else if (req_size == SZ_WORD) w_next = ST_WR;
                    else                         w_next = ST_RMW_RD;
                end
            end
            ST_RD:     w_next = ST_RESP;
            ST_RMW_RD: w_next = ST_WR;
            ST_WR:     w_next = ST_RESP;
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lane    <= '0;
            r_size    <= '0;
            r_signed  <= 1'b0;
            r_wdata   <= '0;
            r_merge   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_address <= '0;
        end else begin
            if (w_accept) begin
                r_lane   <= req_addr[1:0];
                r_size   <= req_size;
                r_signed <= req_signed;
                r_wdata  <= req_wdata;
                r_err    <= w_err;
                r_rdata  <= '0;
                // The memory-side address/data only move for a real access.
                if (!w_err) r_address <= w_base;
                if (!w_err && req_write && req_size == SZ_WORD) r_merge <= req_wdata;
            end
            if (r_state == ST_RD)     r_rdata <= w_load;
            if (r_state == ST_RMW_RD) r_merge <= w_merged;
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign address    = r_address;
    assign write_data = r_merge;
    // Strobes are gated by reset so an aborted operation never touches memory.
    assign _mem_read  = rst_n && (r_state == ST_RD || r_state == ST_RMW_RD);
    assign _mem_write = rst_n && (r_state == ST_WR);

endmodule

`default_nettype wire

// File: tb/tb_mem_master.sv
// =============================================================================
//  tb_mem_master : directed bench for mem_master with a byte-array reference
//  Revision: 1.0
// =============================================================================
`default_nettype none

module tb_mem_master;

    localparam int MEM_BYTES = 1024;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] base;
        logic [31:0] wword;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, req_valid, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err, mem_rd, mem_wr;
    logic [31:0] resp_rdata, address, write_data, mem_out;

    always #5 clk = ~clk;

    mem_master #(.MEM_BYTES(MEM_BYTES), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .address(address),
        .write_data(write_data), .mem_out(mem_out), ._mem_read(mem_rd),
        ._mem_write(mem_wr)
    );

    // Memory model attached to the port, plus an independent reference image.
    logic [7:0] env_mem [0:MEM_BYTES-1];
    logic [7:0] ref_mem [0:MEM_BYTES-1];
    logic [9:0] ea;
    logic       init_mem = 1'b1;

    assign ea      = address[9:0];
    assign mem_out = {env_mem[ea], env_mem[ea+10'd1], env_mem[ea+10'd2], env_mem[ea+10'd3]};

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < MEM_BYTES; i++) env_mem[i] <= 8'(i * 7 + 3);
        end else if (mem_wr) begin
            env_mem[ea]       <= write_data[7:0];
            env_mem[ea+10'd1] <= write_data[15:8];
            env_mem[ea+10'd2] <= write_data[23:16];
            env_mem[ea+10'd3] <= write_data[31:24];
        end
    end

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    exp_t        exp_q[$];
    int          seen_rd = 0, seen_wr = 0;
    logic [31:0] last_rdata = '0, last_wdata = '0;
    logic        last_err = 1'b0;
    int          last_resp_cyc = -10;
    int          last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain byte-array semantics of every request.
    task automatic model(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, output exp_t e);
        int nb, ia, ib;
        logic [31:0] v;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e.base  = a & ~32'd3;
        e.rdata = '0;
        e.wword = '0;
        e.acc   = 0;
        e.err   = (sz == 2'd3) || ((a % 32'(nb)) != 0)
               || ((64'(e.base) + 64'd3) >= 64'(MEM_BYTES));
        ia = int'(a);
        ib = int'(e.base);
        if (e.err) begin
            e.lat = 2; e.nrd = 0; e.nwr = 0;
        end else if (!wr) begin
            v = '0;
            for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[ia+i]) << (8 * i));
            if (sg && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
            e.rdata = v; e.lat = 3; e.nrd = 1; e.nwr = 0;
        end else begin
            for (int i = 0; i < nb; i++) ref_mem[ia+i] = wd[8*i +: 8];
            e.wword = {ref_mem[ib+3], ref_mem[ib+2], ref_mem[ib+1], ref_mem[ib]};
            e.lat = (nb == 4) ? 3 : 4;
            e.nrd = (nb == 4) ? 0 : 1;
            e.nwr = 1;
        end
    endtask

    // Per-cycle compare process.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (!rst_n) begin
                    check32("outputs_in_reset", {29'b0, resp_valid, mem_rd, mem_wr}, 32'd0);
                    seen_rd = 0; seen_wr = 0;
                end else begin
                    check32("req_ready", {31'b0, req_ready}, {31'b0, exp_q.size() == 0});
                    if (mem_rd || mem_wr) begin
                        if (exp_q.size() == 0) begin
                            check32("stray_strobe", {30'b0, mem_rd, mem_wr}, 32'd0);
                        end else begin
                            check32("address", address, exp_q[0].base);
                            if (mem_wr) begin
                                check32("write_data", write_data, exp_q[0].wword);
                                last_wdata = write_data;
                            end
                        end
                        seen_rd += int'(mem_rd);
                        seen_wr += int'(mem_wr);
                    end
                    if (resp_valid) begin
                        if (exp_q.size() == 0) begin
                            check32("stray_resp", {31'b0, resp_valid}, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check32("resp_rdata", resp_rdata, e.rdata);
                            check32("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                            check32("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                            check32("read_strobes", 32'(seen_rd), 32'(e.nrd));
                            check32("write_strobes", 32'(seen_wr), 32'(e.nwr));
                            last_rdata = resp_rdata;
                            last_err   = resp_err;
                            last_resp_cyc = cyc;
                        end
                        seen_rd = 0; seen_wr = 0;
                    end
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input bit track);
        exp_t e;
        int   waited;
        int   acc;
        waited = 0;
        @(negedge clk);
        req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        while (!req_ready && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check32("accept_timeout", {31'b0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
        end
        acc = cyc;
        @(posedge clk);
        if (track) begin
            model(wr, sz, sg, a, wd, e);
            e.acc = acc;
            exp_q.push_back(e);
        end
        last_acc = acc;
    endtask

    task automatic wait_resp();
        int w;
        w = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while (exp_q.size() != 0 && w < 30) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL resp_timeout: %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic txn(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input string name, input logic [31:0] exp_rd,
                       input logic exp_err);
        issue(wr, sz, sg, a, wd, 1'b1);
        wait_resp();
        check32(name, last_rdata, exp_rd);
        check32({name, "_err"}, {31'b0, last_err}, {31'b0, exp_err});
    endtask

    initial begin
        int          bad;
        logic [31:0] saved;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'(i * 7 + 3);
        @(negedge clk);
        init_mem = 1'b0;
        repeat (2) @(negedge clk);

        check32("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check32("rst_resp", {30'b0, resp_valid, resp_err}, 32'd0);
        check32("rst_resp_rdata", resp_rdata, 32'd0);
        check32("rst_address", address, 32'd0);
        check32("rst_write_data", write_data, 32'd0);
        check32("rst_strobes", {30'b0, mem_rd, mem_wr}, 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hAABBCCDD, "st_word_10", 32'h0, 1'b0);
        check32("mem_bytes_10", {env_mem[19], env_mem[18], env_mem[17], env_mem[16]}, 32'hAABBCCDD);
        txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "ld_word_10", 32'hAABBCCDD, 1'b0);
        txn(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, "ld_sbyte_13", 32'hFFFFFFAA, 1'b0);
        txn(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, "ld_uhalf_12", 32'h0000AABB, 1'b0);
        txn(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, "ld_shalf_12", 32'hFFFFAABB, 1'b0);
        txn(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, "ld_ubyte_11", 32'h000000CC, 1'b0);
        txn(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, "ld_sbyte_10", 32'hFFFFFFDD, 1'b0);

        txn(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000005A, "st_byte_11", 32'h0, 1'b0);
        check32("rmw_write_data", last_wdata, 32'hAABB5ADD);
        txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "ld_after_byte", 32'hAABB5ADD, 1'b0);
        txn(1'b1, 2'd1, 1'b0, 32'h12, 32'hFFFF1234, "st_half_12", 32'h0, 1'b0);
        txn(1'b0, 2'd2, 1'b1, 32'h10, 32'h0, "ld_after_half", 32'h12345ADD, 1'b0);
        txn(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, "ld_shalf_10", 32'h00005ADD, 1'b0);
        txn(1'b1, 2'd0, 1'b0, 32'h13, 32'h00000099, "st_byte_13", 32'h0, 1'b0);
        txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "ld_after_b13", 32'h99345ADD, 1'b0);

        txn(1'b0, 2'd1, 1'b0, 32'h11,  32'h0, "err_half_11", 32'h0, 1'b1);
        txn(1'b0, 2'd2, 1'b0, 32'h12,  32'h0, "err_word_12", 32'h0, 1'b1);
        txn(1'b0, 2'd3, 1'b0, 32'h10,  32'h0, "err_size3", 32'h0, 1'b1);
        txn(1'b0, 2'd2, 1'b0, 32'h3FE, 32'h0, "err_word_3fe", 32'h0, 1'b1);
        txn(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, "err_word_400", 32'h0, 1'b1);
        txn(1'b1, 2'd0, 1'b0, 32'h400, 32'h12, "err_stbyte_400", 32'h0, 1'b1);
        txn(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, "ld_word_3fc", 32'hFCF5EEE7, 1'b0);

        // Reset landing in the write cycle of a word store.
        saved = {env_mem[35], env_mem[34], env_mem[33], env_mem[32]};
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, 1'b0);
        #1;
        rst_n = 1'b0;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check32("abort_ready", {31'b0, req_ready}, 32'd1);
        check32("abort_mem_20", {env_mem[35], env_mem[34], env_mem[33], env_mem[32]}, saved);

        // req_valid held high across two requests.
        issue(1'b1, 2'd0, 1'b0, 32'h30, 32'h00000077, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1'b1);
        check32("b2b_accept_cycle", 32'(last_acc), 32'(last_resp_cyc + 1));
        wait_resp();
        check32("b2b_load", last_rdata, 32'h68615A77);

        repeat (2) @(negedge clk);
        bad = 0;
        for (int i = 0; i < MEM_BYTES; i++) if (env_mem[i] !== ref_mem[i]) bad++;
        check32("mem_image_mismatches", 32'(bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/mem_master.md
Name: mem_master

Overview:
- Initiator side of the byte-addressed data memory port: turns CPU load/store requests (byte, half, word; signed or unsigned loads) into memory read and write strobes.
- Stores narrower than a word are done as read-modify-write, because the memory always writes 4 bytes.
- Handles the memory's byte-order convention:
  - Read data has the byte at the access address in bits [31:24].
  - Write data has the byte at the access address in bits [7:0].
- Sits between the datapath's load/store stage and the memory. Provides a valid/ready request port and a one-cycle response pulse.

Parameters:
- MEM_BYTES, 1024, memory size in bytes. Any access touching a byte at or above this address is an error.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  synchronous reset, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit idle and accepting; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_signed  in  1  sign-extend load result
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result, extended; 0 for stores and errors
- resp_err  out  1  qualified by resp_valid: misaligned, illegal size or out of range
- address  out  ADDR_W  memory address, always word-aligned base
- write_data  out  32  memory write data, byte at base in [7:0]
- mem_out  in  32  memory read data (combinational), byte at base in [31:24]
- _mem_read  out  1  memory read strobe
- _mem_write  out  1  memory write strobe; commits at the posedge ending the strobe cycle

Behaviour:
- Reset values (rst_n low at posedge):
  - state = IDLE.
  - resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - All captured registers = 0.
  - _mem_read and _mem_write are combinationally gated by rst_n, so no strobe is seen during any reset cycle, including a reset that lands mid-operation.
- Handshake:
  - Accept on posedge with req_valid && req_ready.
  - Capture addr, size, signed, write, wdata.
  - Compute base = {addr[ADDR_W-1:2], 2'b00} and lane = addr[1:0].
- Error check at accept (sets resp_err; no memory access, next state RESP):
  - size == 3.
  - Half access with lane[0] == 1.
  - Word access with lane != 0.
  - base + 3 >= MEM_BYTES.
- FSM states: IDLE, RD, RMW_RD, WR, RESP.
  - IDLE: req_ready = 1.
    - Error -> RESP.
    - Load -> RD.
    - Word store -> WR.
    - Byte/half store -> RMW_RD.
  - RD: _mem_read = 1, address = base. Capture mem_out at the posedge -> RESP.
  - RMW_RD: same as RD, but captured word goes to the merge buffer -> WR.
  - WR: _mem_write = 1, address = base, write_data = merge buffer (word store: req_wdata as-is) -> RESP.
  - RESP: resp_valid = 1 for exactly one cycle -> IDLE.
- Latency: load 3 cycles, word store 3, sub-word store 4, error 2 (accept edge to resp_valid edge inclusive). No back-to-back acceptance: req_ready is low from accept until back in IDLE.
- Byte reorder of read word r: le = {r[7:0], r[15:8], r[23:16], r[31:24]}, so le[7:0] is the byte at base.
- Load extract:
  - Byte: le[8*lane +: 8].
  - Half: le[8*lane +: 16].
  - Word: le.
  - Zero- or sign-extended per req_signed; req_signed is ignored for word loads.
- Store merge: replace bytes lane..lane+size of le with the low bytes of req_wdata; all other bytes are preserved.
- Outside RD/RMW_RD/WR:
  - Both strobes are 0.
  - address and write_data hold their last values.

Decomposition:
- Package mem_pkg holds:
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - State enum.
  - Function byte_swap32.
- Sub-module mem_lane_align, purely combinational, does extract/extend and merge. Inputs: le, lane, size, signed, wdata. Outputs: load value, merged word.

Test Plan:
- Word store 0xAABBCCDD to addr 0x10, then word load from 0x10 -> memory bytes 0x10..0x13 = DD, CC, BB, AA; load returns 0xAABBCCDD, resp_err = 0, resp_valid 3 cycles after accept.
- After the above, signed byte load at 0x13 -> 0xFFFFFFAA. Unsigned half load at 0x12 -> 0x0000AABB.
- Byte store 0x5A to 0x11 -> exactly one _mem_read cycle then one _mem_write cycle with write_data = 0xAABB5ADD; subsequent word load = 0xAABB5ADD.
- Half load at 0x11, word load at 0x12, size 3, and word load at 0x3FE (MEM_BYTES = 1024) -> each gives resp_err = 1, resp_rdata = 0, no strobe asserted, latency 2.
- rst_n low during the WR cycle of a word store to 0x20 -> _mem_write low in that cycle, memory at 0x20 unchanged, state IDLE, req_ready = 1 after release, resp_valid never pulses.
- req_valid held high across two requests -> second accepted only in the cycle after the first resp_valid; exactly one resp_valid per accept.
